// File: rtl/snoop_pkg.sv
// Shared definitions for the snoop responder.
// Bus op codes, MSI line-state codes, the responder FSM state type and the
// bit positions of the op/addr/data fields inside a 22-bit CDB word.
package snoop_pkg;

    localparam int CDB_W        = 22;
    localparam int CDB_OP_LSB   = 20;
    localparam int CDB_ADDR_LSB = 16;
    localparam int CDB_DATA_LSB = 0;

    typedef enum logic [1:0] {
        OP_IDLE   = 2'b00,
        OP_BUSRD  = 2'b01,
        OP_BUSRDX = 2'b10,
        OP_FLUSH  = 2'b11
    } bus_op_e;

    // MSI_RSVD is storable but never counts as a valid copy.
    typedef enum logic [1:0] {
        MSI_I    = 2'b00,
        MSI_S    = 2'b01,
        MSI_M    = 2'b10,
        MSI_RSVD = 2'b11
    } msi_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_READ_L1,
        ST_FLUSH,
        ST_UPDATE
    } snoop_state_e;

    function automatic logic is_snoop_op(input logic [1:0] op);
        return (op == OP_BUSRD) || (op == OP_BUSRDX);
    endfunction

endpackage

// File: rtl/msi_tag_table.sv
// Per-line tag and MSI state storage.
// Ports:
//   clk_sys, rst                      clock, async active-high reset
//   snp_we/snp_index/snp_state        snoop write port (state only, wins on same index)
//   loc_we/loc_index/loc_tag/loc_state  core write port (tag and state)
//   lookup_index -> lookup_state/tag  combinational read for the snoop FSM
//   core_index   -> core_state/tag    combinational read for the core
module msi_tag_table #(
    parameter int NLINES = 4,
    parameter int IW     = 2,
    parameter int TW     = 2
) (
    input  logic          clk_sys,
    input  logic          rst,
    input  logic          snp_we,
    input  logic [IW-1:0] snp_index,
    input  logic [1:0]    snp_state,
    input  logic          loc_we,
    input  logic [IW-1:0] loc_index,
    input  logic [TW-1:0] loc_tag,
    input  logic [1:0]    loc_state,
    input  logic [IW-1:0] lookup_index,
    output logic [1:0]    lookup_state,
    output logic [TW-1:0] lookup_tag,
    input  logic [IW-1:0] core_index,
    output logic [1:0]    core_state,
    output logic [TW-1:0] core_tag
);

    logic [1:0]    state_q [NLINES];
    logic [TW-1:0] tag_q   [NLINES];

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NLINES; i++) begin
                state_q[i] <= 2'b00;
                tag_q[i]   <= '0;
            end
        end else begin
            if (loc_we && !(snp_we && (snp_index == loc_index))) begin
                state_q[loc_index] <= loc_state;
                tag_q[loc_index]   <= loc_tag;
            end
            if (snp_we) begin
                state_q[snp_index] <= snp_state;
            end
        end
    end

    assign lookup_state = state_q[lookup_index];
    assign lookup_tag   = tag_q[lookup_index];
    assign core_state   = state_q[core_index];
    assign core_tag     = tag_q[core_index];

endmodule

// File: rtl/snoop_responder.sv
// MSI snoop responder: watches foreign BusRd/BusRdX cycles on the CDB,
// looks the line up in the local tag table, signals sharing, flushes
// modified data over the CDB through the arbiter, and downgrades or
// invalidates the line. The core writes line state through a side port.
// Ports:
//   Clock, Reset                       clock, async active-high reset
//   CDB_Valid, CDB, Bus_Own            observed bus cycle
//   Flush_Req, Flush_Gnt, Flush_Bus    flush request/grant and flush word
//   Snoop_Shared                       one-cycle "held in S" pulse
//   L1_Re, L1_Addr, L1_Data            read of local L1 data for a flush
//   Loc_We, Loc_Index, Loc_Tag, Loc_State, Loc_Ack   core-side state write
//   Rd_Index, Rd_State, Rd_Tag         core-side combinational lookup
//   Busy, Overrun                      FSM busy, sticky dropped-snoop flag
//
// state      | meaning
// IDLE       | waiting for a foreign BusRd/BusRdX
// LOOKUP     | compare captured tag against the table (one cycle)
// READ_L1    | L1_Re high for the captured index
// FLUSH      | Flush_Req high with the flush word until granted
// UPDATE     | write the downgraded/invalidated state, back to IDLE
module snoop_responder
    import snoop_pkg::*;
#(
    parameter int NLINES = 4,
    parameter int AW     = 4,
    parameter int DW     = 16
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          CDB_Valid,
    input  logic [CDB_W-1:0]              CDB,
    input  logic                          Bus_Own,
    output logic                          Flush_Req,
    input  logic                          Flush_Gnt,
    output logic [CDB_W-1:0]              Flush_Bus,
    output logic                          Snoop_Shared,
    output logic                          L1_Re,
    output logic [$clog2(NLINES)-1:0]     L1_Addr,
    input  logic [DW-1:0]                 L1_Data,
    input  logic                          Loc_We,
    input  logic [$clog2(NLINES)-1:0]     Loc_Index,
    input  logic [AW-$clog2(NLINES)-1:0]  Loc_Tag,
    input  logic [1:0]                    Loc_State,
    output logic                          Loc_Ack,
    input  logic [$clog2(NLINES)-1:0]     Rd_Index,
    output logic [1:0]                    Rd_State,
    output logic [AW-$clog2(NLINES)-1:0]  Rd_Tag,
    output logic                          Busy,
    output logic                          Overrun
);

    localparam int IW = $clog2(NLINES);
    localparam int TW = AW - IW;

    snoop_state_e  state;
    logic [1:0]    cap_op;
    logic [AW-1:0] cap_addr;
    logic [IW-1:0] cap_index;
    logic [TW-1:0] cap_tag;

    logic [1:0]    cdb_op;
    logic [AW-1:0] cdb_addr;
    logic          unused_cdb_data;
    logic          foreign_snoop;

    logic [1:0]    lk_state;
    logic [TW-1:0] lk_tag;
    logic          lookup_hit;

    logic          snp_we;
    logic [1:0]    snp_state;
    logic          loc_blocked;

    assign cdb_op          = CDB[CDB_OP_LSB +: 2];
    assign cdb_addr        = CDB[CDB_ADDR_LSB +: AW];
    assign unused_cdb_data = ^CDB[CDB_DATA_LSB +: DW];
    assign foreign_snoop   = CDB_Valid && !Bus_Own && is_snoop_op(cdb_op);

    assign cap_index = cap_addr[IW-1:0];
    assign cap_tag   = cap_addr[AW-1:IW];

    // Reserved state 11 is never a hit.
    assign lookup_hit = ((lk_state == MSI_S) || (lk_state == MSI_M)) && (lk_tag == cap_tag);

    // UPDATE is only reached by BusRd from M (-> S) or by BusRdX (-> I).
    assign snp_we    = (state == ST_UPDATE);
    assign snp_state = (cap_op == OP_BUSRD) ? MSI_S : MSI_I;

    assign Busy = (state != ST_IDLE);

    // The core must not touch the line being snooped, and UPDATE belongs to the snoop.
    assign loc_blocked = (state == ST_UPDATE) || (Busy && (Loc_Index == cap_index));
    assign Loc_Ack     = Loc_We && !Reset && !loc_blocked;

    msi_tag_table #(
        .NLINES (NLINES),
        .IW     (IW),
        .TW     (TW)
    ) u_table (
        .clk_sys      (Clock),
        .rst          (Reset),
        .snp_we       (snp_we),
        .snp_index    (cap_index),
        .snp_state    (snp_state),
        .loc_we       (Loc_Ack),
        .loc_index    (Loc_Index),
        .loc_tag      (Loc_Tag),
        .loc_state    (Loc_State),
        .lookup_index (cap_index),
        .lookup_state (lk_state),
        .lookup_tag   (lk_tag),
        .core_index   (Rd_Index),
        .core_state   (Rd_State),
        .core_tag     (Rd_Tag)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state        <= ST_IDLE;
            cap_op       <= OP_IDLE;
            cap_addr     <= '0;
            Flush_Req    <= 1'b0;
            Flush_Bus    <= '0;
            Snoop_Shared <= 1'b0;
            L1_Re        <= 1'b0;
            L1_Addr      <= '0;
            Overrun      <= 1'b0;
        end else begin
            Snoop_Shared <= 1'b0;
            L1_Re        <= 1'b0;
            if ((state != ST_IDLE) && foreign_snoop) begin
                Overrun <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (foreign_snoop) begin
                        cap_op   <= cdb_op;
                        cap_addr <= cdb_addr;
                        state    <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (!lookup_hit) begin
                        state <= ST_IDLE;
                    end else if (lk_state == MSI_M) begin
                        L1_Re   <= 1'b1;
                        L1_Addr <= cap_index;
                        state   <= ST_READ_L1;
                    end else if (cap_op == OP_BUSRD) begin
                        Snoop_Shared <= 1'b1;
                        state        <= ST_IDLE;
                    end else begin
                        state <= ST_UPDATE;
                    end
                end
                ST_READ_L1: begin
                    // L1_Data is valid on the edge that closes the L1_Re cycle.
                    Flush_Req <= 1'b1;
                    Flush_Bus <= {OP_FLUSH, cap_addr, L1_Data};
                    state     <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    if (Flush_Gnt) begin
                        Flush_Req <= 1'b0;
                        state     <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snoop_responder.sv
// Self-checking bench for snoop_responder: directed scenarios plus a random
// mix of core writes and foreign snoops against a line-level MSI model.
module tb_snoop_responder;

    localparam logic [1:0] OP_RD  = 2'b01;
    localparam logic [1:0] OP_RDX = 2'b10;
    localparam logic [1:0] ST_I   = 2'b00;
    localparam logic [1:0] ST_S   = 2'b01;
    localparam logic [1:0] ST_M   = 2'b10;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        CDB_Valid;
    logic [21:0] CDB;
    logic        Bus_Own;
    logic        Flush_Req;
    logic        Flush_Gnt;
    logic [21:0] Flush_Bus;
    logic        Snoop_Shared;
    logic        L1_Re;
    logic [1:0]  L1_Addr;
    logic [15:0] L1_Data;
    logic        Loc_We;
    logic [1:0]  Loc_Index;
    logic [1:0]  Loc_Tag;
    logic [1:0]  Loc_State;
    logic        Loc_Ack;
    logic [1:0]  Rd_Index;
    logic [1:0]  Rd_State;
    logic [1:0]  Rd_Tag;
    logic        Busy;
    logic        Overrun;

    int vectors = 0;
    int miscompares = 0;

    logic [1:0] m_state [4];
    logic [1:0] m_tag   [4];
    logic       m_overrun;

    int         r_sel;
    int         r_idx;
    logic [1:0] r_tag;
    logic [1:0] r_op;

    snoop_responder dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .CDB_Valid    (CDB_Valid),
        .CDB          (CDB),
        .Bus_Own      (Bus_Own),
        .Flush_Req    (Flush_Req),
        .Flush_Gnt    (Flush_Gnt),
        .Flush_Bus    (Flush_Bus),
        .Snoop_Shared (Snoop_Shared),
        .L1_Re        (L1_Re),
        .L1_Addr      (L1_Addr),
        .L1_Data      (L1_Data),
        .Loc_We       (Loc_We),
        .Loc_Index    (Loc_Index),
        .Loc_Tag      (Loc_Tag),
        .Loc_State    (Loc_State),
        .Loc_Ack      (Loc_Ack),
        .Rd_Index     (Rd_Index),
        .Rd_State     (Rd_State),
        .Rd_Tag       (Rd_Tag),
        .Busy         (Busy),
        .Overrun      (Overrun)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_state[i] = ST_I;
            m_tag[i]   = 2'b00;
        end
        m_overrun = 1'b0;
    endtask

    task automatic check_line(input int idx);
        Rd_Index = idx[1:0];
        #1;
        chk("rd_state", 32'(Rd_State), 32'(m_state[idx]));
        chk("rd_tag", 32'(Rd_Tag), 32'(m_tag[idx]));
    endtask

    task automatic loc_write(input int idx, input logic [1:0] tg, input logic [1:0] st);
        Loc_We    = 1'b1;
        Loc_Index = idx[1:0];
        Loc_Tag   = tg;
        Loc_State = st;
        #1;
        chk("loc_ack_idle", 32'(Loc_Ack), 1);
        tick();
        Loc_We = 1'b0;
        m_state[idx] = st;
        m_tag[idx]   = tg;
        check_line(idx);
    endtask

    // Full foreign snoop with the expected response derived from the model's MSI rules.
    task automatic do_snoop(input logic [1:0] op, input logic [3:0] addr,
                            input logic [15:0] data, input int gnt_delay);
        int          idx;
        logic [1:0]  st;
        logic        hit;
        logic [21:0] word;
        idx  = int'(addr[1:0]);
        st   = m_state[idx];
        hit  = ((st == ST_S) || (st == ST_M)) && (m_tag[idx] == addr[3:2]);
        word = {2'b11, addr, data};
        L1_Data   = data;
        CDB_Valid = 1'b1;
        Bus_Own   = 1'b0;
        CDB       = {op, addr, 16'($urandom)};
        tick();
        CDB_Valid = 1'b0;
        CDB       = '0;
        chk("busy_lookup", 32'(Busy), 1);
        tick();
        if (!hit) begin
            chk("miss_idle", 32'(Busy), 0);
            chk("miss_no_req", 32'(Flush_Req), 0);
            chk("miss_no_shared", 32'(Snoop_Shared), 0);
        end else if ((st == ST_S) && (op == OP_RD)) begin
            chk("shared_pulse", 32'(Snoop_Shared), 1);
            chk("shared_idle", 32'(Busy), 0);
            tick();
            chk("shared_once", 32'(Snoop_Shared), 0);
        end else if (st == ST_S) begin
            chk("inv_update", 32'(Busy), 1);
            chk("inv_no_req", 32'(Flush_Req), 0);
            tick();
            chk("inv_done", 32'(Busy), 0);
            chk("inv_no_req_end", 32'(Flush_Req), 0);
            m_state[idx] = ST_I;
        end else begin
            chk("l1_re", 32'(L1_Re), 1);
            chk("l1_addr", 32'(L1_Addr), idx);
            chk("no_req_yet", 32'(Flush_Req), 0);
            tick();
            L1_Data = ~data;
            chk("flush_req_rise", 32'(Flush_Req), 1);
            chk("flush_word", 32'(Flush_Bus), 32'(word));
            chk("l1_re_fall", 32'(L1_Re), 0);
            for (int k = 1; k < gnt_delay; k++) begin
                tick();
                chk("flush_req_hold", 32'(Flush_Req), 1);
                chk("flush_word_hold", 32'(Flush_Bus), 32'(word));
            end
            Flush_Gnt = 1'b1;
            tick();
            Flush_Gnt = 1'b0;
            chk("flush_req_fall", 32'(Flush_Req), 0);
            chk("flush_update", 32'(Busy), 1);
            tick();
            chk("flush_done", 32'(Busy), 0);
            m_state[idx] = (op == OP_RD) ? ST_S : ST_I;
        end
        chk("overrun", 32'(Overrun), 32'(m_overrun));
        check_line(idx);
    endtask

    initial begin
        Reset     = 1'b1;
        CDB_Valid = 1'b0;
        CDB       = '0;
        Bus_Own   = 1'b0;
        Flush_Gnt = 1'b0;
        L1_Data   = '0;
        Loc_We    = 1'b1;
        Loc_Index = 2'd0;
        Loc_Tag   = 2'd0;
        Loc_State = ST_M;
        Rd_Index  = 2'd0;
        model_reset();

        // Reset state
        tick();
        tick();
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_flush_req", 32'(Flush_Req), 0);
        chk("rst_flush_bus", 32'(Flush_Bus), 0);
        chk("rst_shared", 32'(Snoop_Shared), 0);
        chk("rst_l1_re", 32'(L1_Re), 0);
        chk("rst_l1_addr", 32'(L1_Addr), 0);
        chk("rst_loc_ack", 32'(Loc_Ack), 0);
        chk("rst_overrun", 32'(Overrun), 0);
        for (int i = 0; i < 4; i++) check_line(i);
        Reset  = 1'b0;
        Loc_We = 1'b0;
        tick();

        // Line 2 in M tag 1, foreign BusRd 0x6, grant after two cycles
        loc_write(2, 2'd1, ST_M);
        do_snoop(OP_RD, 4'h6, 16'hBEEF, 2);

        // Line 1 in S tag 3, foreign BusRdX 0xD -> invalidated, no flush
        loc_write(1, 2'd3, ST_S);
        do_snoop(OP_RDX, 4'hD, 16'h1111, 1);

        // Line 0 in S, foreign BusRd 0x0 -> shared pulse, state kept
        loc_write(0, 2'd0, ST_S);
        do_snoop(OP_RD, 4'h0, 16'h2222, 1);

        // Same op issued by this core, then non-snoop ops: all ignored
        CDB_Valid = 1'b1;
        Bus_Own   = 1'b1;
        CDB       = {OP_RD, 4'h0, 16'h1234};
        tick();
        Bus_Own = 1'b0;
        CDB     = {2'b11, 4'h0, 16'h5678};
        chk("own_ignored", 32'(Busy), 0);
        tick();
        CDB = {2'b00, 4'h0, 16'h0000};
        chk("own_no_shared", 32'(Snoop_Shared), 0);
        chk("flush_op_ignored", 32'(Busy), 0);
        tick();
        CDB_Valid = 1'b0;
        chk("idle_op_ignored", 32'(Busy), 0);
        check_line(0);

        // Local write collides with snoop on index 1; second snoop while busy
        loc_write(1, 2'd0, ST_S);
        CDB_Valid = 1'b1;
        Bus_Own   = 1'b0;
        CDB       = {OP_RDX, 4'h1, 16'h0000};
        tick();
        CDB       = {OP_RD, 4'h2, 16'h0000};
        Loc_We    = 1'b1;
        Loc_Index = 2'd1;
        Loc_Tag   = 2'd2;
        Loc_State = ST_M;
        #1;
        chk("loc_blocked_busy", 32'(Loc_Ack), 0);
        tick();
        CDB_Valid = 1'b0;
        #1;
        chk("overrun_set", 32'(Overrun), 1);
        chk("update_busy", 32'(Busy), 1);
        chk("loc_blocked_update", 32'(Loc_Ack), 0);
        tick();
        Loc_We = 1'b0;
        m_state[1] = ST_I;
        m_overrun  = 1'b1;
        chk("dropped_snoop", 32'(Busy), 0);
        check_line(1);
        loc_write(1, 2'd2, ST_M);

        // Random mix of core writes and foreign snoops
        for (int n = 0; n < 40; n++) begin
            r_sel = int'($urandom_range(0, 9));
            r_idx = int'($urandom_range(0, 3));
            if (r_sel < 4) begin
                loc_write(r_idx, 2'($urandom), 2'($urandom));
            end else begin
                r_tag = ($urandom_range(0, 1) == 1) ? m_tag[r_idx] : 2'($urandom);
                r_op  = ($urandom_range(0, 1) == 1) ? OP_RD : OP_RDX;
                do_snoop(r_op, {r_tag, r_idx[1:0]}, 16'($urandom), int'($urandom_range(1, 3)));
            end
        end

        // Reset while Flush_Req is high
        loc_write(2, 2'd1, ST_M);
        L1_Data   = 16'hC0DE;
        CDB_Valid = 1'b1;
        CDB       = {OP_RD, 4'h6, 16'h0000};
        tick();
        CDB_Valid = 1'b0;
        tick();
        tick();
        chk("pre_rst_flush_req", 32'(Flush_Req), 1);
        Reset = 1'b1;
        #1;
        model_reset();
        chk("rst_drops_flush_req", 32'(Flush_Req), 0);
        chk("rst_drops_busy", 32'(Busy), 0);
        chk("rst_clears_overrun", 32'(Overrun), 0);
        chk("rst_clears_flush_bus", 32'(Flush_Bus), 0);
        for (int i = 0; i < 4; i++) check_line(i);
        tick();
        Reset = 1'b0;
        tick();
        chk("post_rst_busy", 32'(Busy), 0);
        check_line(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/snoop_responder.md
SNOOP_RESPONDER -- requirements
Module: snoop_responder

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: Clock in 1, rising-edge clock; Reset in 1, asynchronous active-high reset.
REQ-002 SHALL have these parameters (name, default, meaning): NLINES, 4, tag-table entries; AW, 4, address width; DW, 16, data width.
REQ-003 SHALL have these ports (name, direction, width, meaning):
- CDB_Valid  in  1  bus cycle valid.
- CDB  in  22  {op[21:20], addr[19:16], data[15:0]}.
- Bus_Own  in  1  current CDB transaction was issued by this core.
- Flush_Req  out  1  request to drive CDB.
- Flush_Gnt  in  1  arbiter grant.
- Flush_Bus  out  22  flush word.
- Snoop_Shared  out  1  one-cycle pulse, line held in S.
- L1_Re  out  1  read of local L1 data.
- L1_Addr  out  2  index for that read.
- L1_Data  in  16  L1 read data.
- Loc_We  in  1  core-side state write.
- Loc_Index  in  2  target line.
- Loc_Tag  in  2  tag to store.
- Loc_State  in  2  state to store.
- Loc_Ack  out  1  core-side write accepted this cycle.
- Rd_Index  in  2  core lookup index.
- Rd_State  out  2  combinational state of Rd_Index.
- Rd_Tag  out  2  combinational tag of Rd_Index.
- Busy  out  1  FSM not in IDLE.
- Overrun  out  1  sticky: foreign snoop arrived while Busy.

Function
REQ-004 Bus op encoding SHALL be: 00 idle, 01 BusRd, 10 BusRdX (read-exclusive/upgrade), 11 Flush; MSI encoding SHALL be: 00 I, 01 S, 10 M, 11 reserved (treated as I).
REQ-005 Index SHALL be addr[1:0] and tag SHALL be addr[3:2]; a hit SHALL require state != I and a tag match.
REQ-006 FSM states SHALL be IDLE, LOOKUP, READ_L1, FLUSH, UPDATE.
REQ-007 IDLE SHALL capture op and addr and go to LOOKUP when CDB_Valid=1, Bus_Own=0 and op is 01 or 10; op 00/11 and own transactions SHALL be ignored.
REQ-008 LOOKUP SHALL take exactly one cycle and exit as follows:
- miss -> IDLE.
- BusRd hit in S -> Snoop_Shared pulse, then IDLE.
- BusRdX hit in S -> UPDATE.
- any hit in M -> READ_L1.
REQ-009 READ_L1 SHALL assert L1_Re=1 with L1_Addr=index for one cycle; L1_Data SHALL be registered on the following edge, and the FSM then enters FLUSH.
REQ-010 FLUSH SHALL hold Flush_Req=1 and Flush_Bus={2'b11, addr, data} stable until a rising edge with Flush_Gnt=1, then go to UPDATE; Flush_Req SHALL fall on that edge.
REQ-011 UPDATE SHALL write the next state, then return to IDLE:
- BusRd: M -> S.
- BusRdX: S/M -> I.
REQ-012 Snoop latency SHALL be:
- miss: 2 cycles, capture to IDLE.
- S invalidation: 3 cycles.
- M flush: Flush_Req first high 3 cycles after capture.
REQ-013 Loc_We SHALL be applied and Loc_Ack=1 in the same cycle, except:
- the UPDATE cycle, where the snoop write wins;
- when Loc_Index equals the captured index while Busy=1.
In both cases Loc_Ack=0 and the write is not performed; the core retries.
REQ-014 A foreign valid BusRd/BusRdX arriving while Busy=1 SHALL be dropped and SHALL set Overrun.
REQ-015 Rd_State/Rd_Tag SHALL reflect table contents combinationally, including writes from the previous edge.

Reset
REQ-016 Reset SHALL force the following, asynchronously:
- FSM to IDLE; all states to I; tags to 0.
- Flush_Req, Snoop_Shared, L1_Re, Loc_Ack, Busy and Overrun to 0.
- Flush_Bus and L1_Addr to 0.
REQ-017 Reset during FLUSH SHALL drop Flush_Req immediately, with no state update.

Structure
REQ-018 The op codes, MSI codes, FSM state enum and CDB field positions SHALL live in shared package snoop_pkg.
REQ-019 The tag/state array SHALL be a sub-module msi_tag_table with two write ports (snoop, local; snoop priority) and two combinational read ports.

Verification
REQ-020 A bench SHALL cover these directed scenarios:
- Line 2 in M, tag 1; foreign BusRd addr 0x6; L1_Data=0xBEEF; Flush_Gnt after 2 cycles -> Flush_Bus=0x36BEEF held 2 cycles, then line 2 in S.
- Line 1 in S, tag 3; foreign BusRdX addr 0xD -> line 1 in I 3 cycles after capture, no Flush_Req.
- Line 0 in S; foreign BusRd addr 0x0 -> single Snoop_Shared pulse, state unchanged; same op with Bus_Own=1 -> no response.
- Snoop in UPDATE on index 1 plus Loc_We index 1 in the same cycle -> Loc_Ack=0, snoop state stored; second foreign snoop while Busy -> Overrun=1.
- Reset asserted while Flush_Req=1 -> Flush_Req=0 and all Rd_State=I without a clock edge.
